mpu_matrix_streamer: RTL and testbench
======================================

# mpu_matrix_streamer

Sequential unloader for the MPU's flattened 5x5 signed 8-bit matrix bus. It captures a full 200-bit matrix, for example the product of a scalar-multiply stage, in one cycle. It then streams the 25 elements out one per accepted transfer over a valid/ready handshake, with the column/row coordinates of each element. It sits between the combinational MPU operation units and any byte-wide consumer such as a result FIFO, a bus bridge or a display path.

## Interface

Parameters:
- DIM, 5, matrix dimension; only 5 is supported.
- WIDTH, 8, element width in bits; only 8 is supported.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  capture request; honoured only in IDLE.
- matrix  input  200  flattened signed matrix. Element (col,row) occupies bits [8*(row+5*col) +: 8].
- out_data  output  8  current signed element.
- out_col  output  3  column index of out_data, 0..4.
- out_row  output  3  row index of out_data, 0..4.
- out_last  output  1  high with element (4,4).
- out_valid  output  1  out_data/out_col/out_row/out_last are valid.
- out_ready  input  1  consumer accepts the current element.
- busy  output  1  high in STREAM and DONE.
- done  output  1  one-cycle pulse after the last element is accepted.

## Operation

- Clock is clk; reset is asynchronous, active-low on rst_n. All registers clear immediately on rst_n=0, independent of clk.
- Reset values: out_data=0, out_col=0, out_row=0, out_last=0, out_valid=0, busy=0, done=0, state=IDLE, internal index=0.
- States and transitions:
  - IDLE: start=1 registers matrix into an internal 200-bit buffer, sets index=0 and moves to STREAM. start=0 stays in IDLE.
  - STREAM: out_valid=1, presenting buffer element `index`. A transfer occurs on a cycle where out_valid & out_ready are both 1. A transfer with index<24 increments index. A transfer with index=24 moves to DONE.
  - DONE: out_valid=0 and done=1 for exactly one cycle, then the block returns to IDLE unconditionally.
- Order: index k = row + 5*col. The row increments first, so the sequence is (0,0),(0,1)..(0,4),(1,0)..(4,4). out_col = k/5, out_row = k%5, out_last = (k==24).
- Data is taken bit-exact from the buffer and is signed two's complement. No arithmetic, saturation or sign change is applied.
- The matrix input is sampled only on the accepted start edge. Later changes to matrix do not affect the stream in progress.
- start in STREAM or DONE is ignored and is not queued.
- Stall: while out_ready=0 in STREAM, out_data, out_col, out_row, out_last and out_valid hold stable.
- Once raised, out_valid does not drop until that element is transferred or reset occurs.
- Reset mid-stream: outputs return to their reset values at once. The stream is abandoned, and no done pulse is produced.

## Timing

- Capture latency: start accepted at edge N gives out_valid=1 with element (0,0) after edge N.
- Throughput: with out_ready held at 1, one element transfers per cycle. Element 24 transfers at edge N+25, done=1 during the following cycle, and state=IDLE after edge N+26.
- Minimum start-to-start period is 27 cycles. A start asserted in the DONE cycle is dropped; a start asserted on the first IDLE cycle is accepted.
- busy=1 from the cycle after the start edge through the DONE cycle inclusive.
- All outputs are registered; out_ready and start have no combinational path to any output.

## Test plan

- Reset and idle: assert rst_n=0 mid-cycle. All outputs go to 0 without a clock edge. Release with start=0 for 10 cycles; out_valid and busy stay 0.
- Full stream, no stall: load matrix with element k = k-12 (so -12..12) and pulse start with out_ready=1.
  - 25 consecutive transfers with out_data = 0xF4,0xF5..0x0C and (col,row) = (0,0),(0,1)..(4,4).
  - out_last=1 only on the 25th transfer; done pulses once, 26 cycles after start.
- Backpressure: same matrix, out_ready toggling 1,0,0,1 repeating.
  - Each element is held stable across stalled cycles and none is skipped or duplicated.
  - done asserts only after (4,4) is accepted.
- Ignored start and input isolation: pulse start again at transfer 5 with a matrix of all 0x7F. The stream continues with the original data, and no second stream follows done.
- Reset mid-stream: assert rst_n=0 after 10 transfers. out_valid drops immediately and done is never pulsed. A new start after reset streams from (0,0).
- Extreme values: a matrix of all 0x80 (-128), then a matrix of all 0x7F (127), are output unchanged. Back-to-back: start on the first IDLE cycle after done is accepted.

Source files
------------

// File: rtl/mpu_matrix_streamer.sv
// mpu_matrix_streamer
//   Captures a flattened DIM x DIM signed matrix in one cycle and streams its
//   elements out one per accepted valid/ready transfer, with coordinates.
//   Element (col,row) sits at matrix[WIDTH*(row+DIM*col) +: WIDTH]; streaming
//   order is row-fastest: (0,0),(0,1)..(0,4),(1,0)..(4,4).
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      capture request, honoured only in IDLE
//   matrix     flattened signed matrix input (DIM*DIM*WIDTH bits)
//   out_data   current signed element
//   out_col    column of out_data
//   out_row    row of out_data
//   out_last   high with the final element (DIM-1,DIM-1)
//   out_valid  out_data/out_col/out_row/out_last are valid
//   out_ready  consumer accepts the current element
//   busy       high from the cycle after capture through the DONE cycle
//   done       one-cycle pulse after the last element is accepted
`timescale 1ns/1ps

module mpu_matrix_streamer #(
    parameter int DIM   = 5,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DIM*DIM*WIDTH-1:0]   matrix,
    output logic [WIDTH-1:0]           out_data,
    output logic [2:0]                 out_col,
    output logic [2:0]                 out_row,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int         NELEM    = DIM * DIM;
    localparam int         BUF_W    = NELEM * WIDTH;
    localparam logic [4:0] LAST_IDX = 5'(NELEM - 1);
    localparam logic [2:0] LAST_RC  = 3'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t             state_q, state_n;
    logic [BUF_W-1:0]   buffer_q, buffer_n;
    logic [4:0]         index_q, index_n;
    logic [WIDTH-1:0]   data_n;
    logic [2:0]         col_n, row_n;
    logic               last_n, valid_n, busy_n, done_n;

    // Outputs are registered copies of the next-cycle view, so the element
    // presented always matches the index held in the state register.
    always_comb begin
        state_n  = state_q;
        buffer_n = buffer_q;
        index_n  = index_q;
        data_n   = out_data;
        col_n    = out_col;
        row_n    = out_row;
        last_n   = out_last;
        valid_n  = out_valid;
        busy_n   = busy;
        done_n   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n  = STREAM;
                    buffer_n = matrix;
                    index_n  = '0;
                    // The buffer is not loaded yet, so element 0 comes
                    // straight from the input on the capture edge.
                    data_n   = matrix[WIDTH-1:0];
                    col_n    = '0;
                    row_n    = '0;
                    last_n   = 1'b0;
                    valid_n  = 1'b1;
                    busy_n   = 1'b1;
                end
            end

            STREAM: begin
                if (out_ready) begin
                    if (index_q == LAST_IDX) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        index_n = index_q + 5'd1;
                        data_n  = buffer_q[index_n*WIDTH +: WIDTH];
                        if (out_row == LAST_RC) begin
                            row_n = '0;
                            col_n = out_col + 3'd1;
                        end else begin
                            row_n = out_row + 3'd1;
                        end
                        last_n = (index_n == LAST_IDX);
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            buffer_q  <= '0;
            index_q   <= '0;
            out_data  <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            buffer_q  <= buffer_n;
            index_q   <= index_n;
            out_data  <= data_n;
            out_col   <= col_n;
            out_row   <= row_n;
            out_last  <= last_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// tb_mpu_matrix_streamer
//   Scoreboard bench: stimulus pushes the expected element sequence for each
//   accepted capture; a negedge monitor compares the head of the queue with
//   every presented element and pops it on transfer, and tracks the done
//   pulse expected in the cycle after the last transfer.
`timescale 1ns/1ps

module tb_mpu_matrix_streamer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [199:0] matrix;
    logic [7:0]   out_data;
    logic [2:0]   out_col;
    logic [2:0]   out_row;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] col;
        logic [2:0] row;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   exp_done = 1'b0;

    mpu_matrix_streamer #(.DIM(5), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .matrix    (matrix),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_row   (out_row),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Element values for the test matrices: 0 = ramp k-12, 1 = all -128, 2 = all 127.
    function automatic logic [7:0] elem(input int kind, input int k);
        case (kind)
            0:       elem = 8'(k - 12);
            1:       elem = 8'h80;
            2:       elem = 8'h7F;
            default: elem = 8'h00;
        endcase
    endfunction

    function automatic logic [199:0] build(input int kind);
        logic [199:0] m;
        m = '0;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++)
                m[8*(r+5*c) +: 8] = elem(kind, r + 5*c);
        return m;
    endfunction

    task automatic push_stream(input int kind);
        exp_t e;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++) begin
                e.data = elem(kind, r + 5*c);
                e.col  = 3'(c);
                e.row  = 3'(r);
                e.last = (c == 4) && (r == 4);
                exp_q.push_back(e);
            end
    endtask

    // Monitor: compares every presented element against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done = 1'b0;
        end else begin
            if (done === 1'b1 || exp_done)
                chk("done_pulse", {31'd0, done}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data %0h col %0d row %0d expected no element at %0t",
                             out_data, out_col, out_row, $time);
                end else begin
                    mon_e = exp_q[0];
                    chk("stream_element", {17'd0, out_data, out_col, out_row, out_last}, {17'd0, mon_e});
                    if (out_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        if (mon_e.last) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    // Capture request on the current (IDLE) cycle; element (0,0) must be
    // valid right after the capture edge.
    task automatic start_stream(input int kind);
        push_stream(kind);
        matrix = build(kind);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        matrix = ~matrix;
        chk("capture_valid", {31'd0, out_valid}, 32'd1);
        chk("capture_busy",  {31'd0, busy},      32'd1);
        chk("capture_coord", {26'd0, out_col, out_row}, 32'd0);
    endtask

    // Drive out_ready from a 4-cycle pattern until done is seen; optionally
    // inject a start with an all-127 matrix at cycle inject_at.
    task automatic run_stream(input logic [3:0] pat, input int inject_at, input int exp_cycles);
        int          cyc;
        bit          got;
        int unsigned ph;
        cyc = 0;
        got = 1'b0;
        while (cyc < 200) begin
            ph        = 32'(cyc % 4);
            out_ready = pat[ph];
            if (cyc == inject_at) begin
                start  = 1'b1;
                matrix = build(2);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("done_latency", 32'(cyc), 32'(exp_cycles));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        matrix    = '0;

        // Reset applied before any clock edge.
        #3;
        chk("reset_outputs", {15'd0, out_data, out_col, out_row, out_last, out_valid, busy, done}, 32'd0);
        #9;
        rst_n = 1'b1;

        // Idle with start low.
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_busy",  {31'd0, busy},      32'd0);
        end

        // Full stream, no stall.
        start_stream(0);
        chk("first_data", {24'd0, out_data}, 32'h0000_00F4);
        run_stream(4'b1111, -1, 25);

        // Start during the DONE cycle is dropped.
        matrix = build(2);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_start_valid", {31'd0, out_valid}, 32'd0);
        chk("done_start_busy",  {31'd0, busy},      32'd0);

        // Back-to-back from the first IDLE cycle, with backpressure 1,0,0,1.
        start_stream(0);
        run_stream(4'b1001, -1, 49);
        @(posedge clk);
        #1;

        // Ignored start at transfer 5 with a different matrix.
        start_stream(0);
        run_stream(4'b1111, 5, 25);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no_second_stream", {31'd0, out_valid}, 32'd0);
        end

        // Reset mid-stream after 10 transfers.
        start_stream(0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {15'd0, out_data, out_col, out_row, out_last, out_valid, busy, done}, 32'd0);
        exp_q.delete();
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_reset_valid", {31'd0, out_valid}, 32'd0);
            chk("post_reset_done",  {31'd0, done},      32'd0);
        end
        start_stream(0);
        run_stream(4'b1111, -1, 25);
        @(posedge clk);
        #1;

        // Extreme values, back-to-back.
        start_stream(1);
        chk("min_first", {24'd0, out_data}, 32'h0000_0080);
        run_stream(4'b1111, -1, 25);
        @(posedge clk);
        #1;
        start_stream(2);
        chk("max_first", {24'd0, out_data}, 32'h0000_007F);
        run_stream(4'b1011, -1, 33);
        @(posedge clk);
        #1;
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
